fetch_prefetch_buffer: RTL and testbench

// Sits between instruction memory and the fetch stage of the 5-stage pipeline. Issues in-order

---
 rtl/fetch_prefetch_buffer.sv | 144 ++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer between instruction memory and the fetch stage.
// It issues in-order word fetches, matches in-order responses to allocated
// entries, and presents the oldest completed {pc, instruction} pair.
// A redirect clears the queue. It also counts the in-flight responses that
// must be discarded when they return.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        rsp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DEPTH) + 2;

  // run_reg gives a synchronous release: no request is issued before the first clock after reset.
  logic          run_reg;
  logic [31:0]   fetch_pc_reg;
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [PW-1:0] fill_reg;
  logic [CW-1:0] alloc_cnt_reg;
  logic [CW-1:0] pend_cnt_reg;
  logic [DW-1:0] drop_cnt_reg;
  logic          rsp_err_reg;
  logic          data_ok_reg [DEPTH];
  logic [31:0]   pc_mem      [DEPTH];
  logic [31:0]   data_mem    [DEPTH];

  logic req_fire;
  logic pop;
  logic rsp_drop;
  logic rsp_live;
  logic rsp_fill;
  logic rsp_orphan;
  logic head_ok;

  assign head_ok    = data_ok_reg[head_reg];
  assign req_fire   = imem_req_valid & imem_req_ready;
  assign pop        = inst_valid & inst_ready;

  // A response first pays off outstanding drops. Otherwise it completes the oldest pending entry.
  // If neither applies, it is unsolicited.
  assign rsp_drop   = imem_rsp_valid & (drop_cnt_reg != '0);
  assign rsp_live   = imem_rsp_valid & (drop_cnt_reg == '0) & (pend_cnt_reg != '0);
  assign rsp_orphan = imem_rsp_valid & (drop_cnt_reg == '0) & (pend_cnt_reg == '0);
  // A response that arrives together with a redirect is stale, so it never writes an entry.
  assign rsp_fill   = rsp_live & ~redirect_valid;

  assign imem_req_valid = run_reg & (alloc_cnt_reg < CW'(DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = run_reg ? fetch_pc_reg : 32'h0;

  assign inst_valid     = head_ok & ~redirect_valid;
  assign inst_data      = inst_valid ? data_mem[head_reg] : 32'h0;
  assign inst_pc        = inst_valid ? pc_mem[head_reg] : 32'h0;
  assign inst_pc_plus4  = inst_valid ? (pc_mem[head_reg] + 32'd4) : 32'h0;
  assign rsp_err        = rsp_err_reg;

  // Pointers, occupancy counters, fetch pc, drop accounting and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg       <= 1'b0;
      fetch_pc_reg  <= RESET_PC;
      head_reg      <= '0;
      tail_reg      <= '0;
      fill_reg      <= '0;
      alloc_cnt_reg <= '0;
      pend_cnt_reg  <= '0;
      drop_cnt_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (rsp_orphan) begin
        rsp_err_reg <= 1'b1;
      end
      if (redirect_valid) begin
        // Every pending entry still has a response in flight. A response in this cycle
        // has already retired either one drop or one pending entry.
        fetch_pc_reg  <= redirect_pc;
        head_reg      <= '0;
        tail_reg      <= '0;
        fill_reg      <= '0;
        alloc_cnt_reg <= '0;
        pend_cnt_reg  <= '0;
        drop_cnt_reg  <= drop_cnt_reg - DW'(rsp_drop) + DW'(pend_cnt_reg) - DW'(rsp_live);
      end else begin
        if (req_fire) begin
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
          tail_reg     <= tail_reg + PW'(1);
        end
        if (rsp_fill) begin
          fill_reg <= fill_reg + PW'(1);
        end
        if (pop) begin
          head_reg <= head_reg + PW'(1);
        end
        alloc_cnt_reg <= alloc_cnt_reg + CW'(req_fire) - CW'(pop);
        pend_cnt_reg  <= pend_cnt_reg + CW'(req_fire) - CW'(rsp_fill);
        drop_cnt_reg  <= drop_cnt_reg - DW'(rsp_drop);
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Per-entry completion flag: set on fill, cleared on pop, redirect or reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_ok_reg[gi] <= 1'b0;
      end else if (redirect_valid) begin
        data_ok_reg[gi] <= 1'b0;
      end else if (rsp_fill && (fill_reg == PW'(gi))) begin
        data_ok_reg[gi] <= 1'b1;
      end else if (pop && (head_reg == PW'(gi))) begin
        data_ok_reg[gi] <= 1'b0;
      end
    end

    // Per-entry payload: pc captured at allocation, instruction captured at fill.
    always_ff @(posedge clk) begin
      if (req_fire && (tail_reg == PW'(gi))) begin
        pc_mem[gi] <= fetch_pc_reg;
      end
      if (rsp_fill && (fill_reg == PW'(gi))) begin
        data_mem[gi] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Testbench for fetch_prefetch_buffer: directed table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        rsp_err;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        rd;     logic [31:0] rd_pc;  logic rq_rdy;
    logic        rs_v;   logic [31:0] rs_d;   logic in_rdy;
    logic        e_rq_v; logic [31:0] e_addr;
    logic        e_in_v; logic [31:0] e_pc;   logic [31:0] e_data;
    logic        e_err;
  } vec_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit ok; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a plain queue of {pc, data, complete} in program order.
  ent_t        mq[$];
  int          m_drop;
  bit          m_err;
  bit          m_run;
  logic [31:0] m_pc;

  // Memory model: accepted requests with their due cycle, answered in order.
  mreq_t mem_q[$];
  bit    mem_auto = 1'b0;
  int    lat_lo = 1;
  int    lat_hi = 1;
  bit    track1 = 1'b0;
  int    hs_count = 0;
  int    pop_count = 0;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic [31:0] rd_pc, input logic rq_rdy,
                               input logic rs_v, input logic [31:0] rs_d, input logic in_rdy,
                               input logic e_rq_v, input logic [31:0] e_addr, input logic e_in_v,
                               input logic [31:0] e_pc, input logic [31:0] e_data, input logic e_err);
    vec_t v;
    v.rd = rd; v.rd_pc = rd_pc; v.rq_rdy = rq_rdy; v.rs_v = rs_v; v.rs_d = rs_d; v.in_rdy = in_rdy;
    v.e_rq_v = e_rq_v; v.e_addr = e_addr; v.e_in_v = e_in_v; v.e_pc = e_pc; v.e_data = e_data;
    v.e_err = e_err;
    return v;
  endfunction

  function automatic vec_t rnd_vec(input int p_rd);
    vec_t        v;
    logic [31:0] t;
    v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t = $urandom();
    t[1:0] = 2'b00;
    v.rd     = ($urandom_range(99, 0) < p_rd);
    v.rd_pc  = t;
    v.rq_rdy = ($urandom_range(99, 0) < 70);
    v.in_rdy = ($urandom_range(99, 0) < 60);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    mem_q.delete();
    m_drop = 0;
    m_err  = 1'b0;
    m_run  = 1'b0;
    m_pc   = RESET_PC;
  endtask

  // Asserts reset between clock edges, checks the immediate effect, then releases it.
  task automatic do_reset();
    redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against model (and optional row), advance model.
  task automatic step(input vec_t v, input bit chk);
    logic        rs_v;
    logic [31:0] rs_d;
    logic        e_rq_v;
    logic        e_in_v;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    bit          pop_m;
    bit          hs_m;
    int          idx;
    int          pend;
    mreq_t       mr;
    ent_t        ent;
    rs_v = v.rs_v;
    rs_d = v.rs_d;
    if (mem_auto) begin
      rs_v = 1'b0;
      rs_d = $urandom();
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        mr   = mem_q.pop_front();
        rs_v = 1'b1;
        rs_d = mr.addr ^ 32'hC3C3_0000;
      end
    end
    redirect_valid = v.rd; redirect_pc = v.rd_pc; imem_req_ready = v.rq_rdy;
    imem_rsp_valid = rs_v; imem_rsp_data = rs_d; inst_ready = v.in_rdy;
    #1;
    e_rq_v = m_run && (mq.size() < DEPTH) && !v.rd;
    e_in_v = 1'b0;
    e_pc   = 32'h0;
    e_data = 32'h0;
    if (mq.size() > 0) begin
      if (mq[0].ok && !v.rd) begin
        e_in_v = 1'b1;
        e_pc   = mq[0].pc;
        e_data = mq[0].data;
      end
    end
    check("req_valid", imem_req_valid, e_rq_v);
    if (e_rq_v) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", inst_valid, e_in_v);
    check("inst_pc", inst_pc, e_pc);
    check("inst_data", inst_data, e_data);
    check("inst_pc_plus4", inst_pc_plus4, e_in_v ? e_pc + 32'd4 : 32'h0);
    check("rsp_err", rsp_err, m_err);
    if (chk) begin
      check("row_req_valid", imem_req_valid, v.e_rq_v);
      if (v.e_rq_v) check("row_req_addr", imem_req_addr, v.e_addr);
      check("row_inst_valid", inst_valid, v.e_in_v);
      check("row_inst_pc", inst_pc, v.e_pc);
      check("row_inst_data", inst_data, v.e_data);
      check("row_rsp_err", rsp_err, v.e_err);
    end
    if (track1 && imem_req_valid && v.rq_rdy) begin
      check("t1_req_addr", imem_req_addr, RESET_PC + 32'(4 * hs_count));
      hs_count++;
    end
    if (track1 && inst_valid && v.in_rdy) begin
      check("t1_inst_pc", inst_pc, RESET_PC + 32'(4 * pop_count));
      check("t1_inst_pc_plus4", inst_pc_plus4, RESET_PC + 32'(4 * pop_count + 4));
      pop_count++;
    end
    if (imem_req_valid && v.rq_rdy) $display("cycle %0d: request addr=%h", cyc, imem_req_addr);
    if (inst_valid && v.in_rdy) $display("cycle %0d: deliver pc=%h data=%h", cyc, inst_pc, inst_data);
    if (mem_auto && imem_req_valid && v.rq_rdy)
      mem_q.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});

    // Model advance from pre-edge state.
    pop_m = e_in_v && v.in_rdy;
    hs_m  = e_rq_v && v.rq_rdy;
    if (rs_v) begin
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        idx = -1;
        for (int i = 0; i < mq.size(); i++) if (idx < 0 && !mq[i].ok) idx = i;
        if (idx >= 0) begin
          mq[idx].ok   = 1'b1;
          mq[idx].data = rs_d;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (v.rd) begin
      pend = 0;
      foreach (mq[i]) if (!mq[i].ok) pend++;
      m_drop += pend;
      mq.delete();
      m_pc = v.rd_pc;
    end else begin
      if (pop_m) ent = mq.pop_front();
      if (hs_m) begin
        mq.push_back('{pc: m_pc, data: 32'h0, ok: 1'b0});
        m_pc += 32'd4;
      end
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    // rd rd_pc rq_rdy rs_v rs_d in_rdy | rq_v addr in_v pc data err
    tbl[0]  = mkv(0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 1, 0, 0, 0,                          1, 32'h1000, 0, 0, 0, 0);
    tbl[7]  = mkv(0, 0, 1, 0, 0, 0,                          1, 32'h1004, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 1, 0, 0, 0,                          1, 32'h1008, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 0, 1, 0, 0, 0,                          1, 32'h100C, 0, 0, 0, 0);
    tbl[10] = mkv(0, 0, 1, 1, 32'hD000_0000, 0,              0, 0, 0, 0, 0, 0);
    tbl[11] = mkv(0, 0, 1, 1, 32'hD000_0001, 0,              0, 0, 1, 32'h1000, 32'hD000_0000, 0);
    tbl[12] = mkv(0, 0, 1, 0, 0, 1,                          0, 0, 1, 32'h1000, 32'hD000_0000, 0);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h1010, 1, 32'h1004, 32'hD000_0001, 0);
    tbl[14] = mkv(1, 32'h2000, 1, 0, 0, 1,                   0, 0, 0, 0, 0, 0);
    tbl[15] = mkv(0, 0, 1, 1, 32'hBAD0_0001, 0,              1, 32'h2000, 0, 0, 0, 0);
    tbl[16] = mkv(0, 0, 0, 1, 32'hBAD0_0002, 0,              1, 32'h2004, 0, 0, 0, 0);
    tbl[17] = mkv(0, 0, 0, 1, 32'hD000_2000, 0,              1, 32'h2004, 0, 0, 0, 0);
    tbl[18] = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h2004, 1, 32'h2000, 32'hD000_2000, 0);
    tbl[19] = mkv(0, 0, 1, 0, 0, 0,                          1, 32'h2004, 1, 32'h2000, 32'hD000_2000, 0);
    tbl[20] = mkv(1, 32'h3000, 1, 1, 32'hBAD0_0003, 1,       0, 0, 0, 0, 0, 0);
    tbl[21] = mkv(0, 0, 0, 0, 0, 1,                          1, 32'h3000, 0, 0, 0, 0);
    tbl[22] = mkv(0, 0, 0, 1, 32'hBAD0_0004, 0,              1, 32'h3000, 0, 0, 0, 0);
    tbl[23] = mkv(0, 0, 0, 0, 0, 0,                          1, 32'h3000, 0, 0, 0, 1);
    idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Streaming with latency-1 memory and an always-ready fetch stage.
    do_reset();
    mem_auto = 1'b1; lat_lo = 1; lat_hi = 1; track1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v = idle; v.rq_rdy = 1'b1; v.in_rdy = 1'b1;
      step(v, 1'b0);
    end
    track1 = 1'b0;
    check("t1_requests", hs_count, 39);
    check("t1_deliveries", pop_count, 37);

    // Directed table: stalled ready, full queue, redirect drops, redirect with live response.
    do_reset();
    mem_auto = 1'b0;
    for (int i = 0; i < 24; i++) step(tbl[i], 1'b1);

    // Randomized traffic with occasional redirects.
    do_reset();
    mem_auto = 1'b1; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 1200; i++) step(rnd_vec(5), 1'b0);

    // Reset in the middle of traffic, then an unsolicited response.
    do_reset();
    mem_auto = 1'b0;
    step(idle, 1'b0);
    check("t6_first_req_valid", imem_req_valid, 1'b1);
    check("t6_first_req_addr", imem_req_addr, RESET_PC);
    v = idle; v.rs_v = 1'b1; v.rs_d = 32'h0BAD_F00D;
    step(v, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t6_err_sticky", rsp_err, 1'b1);
      step(idle, 1'b0);
    end

    // More random traffic with frequent redirects.
    do_reset();
    mem_auto = 1'b1; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 800; i++) step(rnd_vec(15), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
